// File: rtl/cosine_engine.sv
// rtl/cosine_engine.sv - truncated Taylor cos/sin series scaled by v, one shared multiplier
module cosine_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 11,
    parameter int TERMS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] v_in,
    input  logic signed [WIDTH-1:0] x_in,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] series,
    output logic signed [WIDTH-1:0] distance
);

    typedef enum logic [2:0] {IDLE, LOAD, ACC_A, ACC_B, SCALE} state_t;

    localparam logic signed [2*WIDTH-1:0] MUL_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] MUL_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0]   WORD_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   WORD_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0]   ONE = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    // Eight negative series coefficients, rounded half-up, packed k=0 in the low slot
    function automatic logic [8*WIDTH-1:0] coefTable(input logic sine);
        logic [8*WIDTH-1:0] tab;
        longint d;
        longint n;
        tab = '0;
        for (int k = 0; k < 8; k++) begin
            d = sine ? longint'((2*k+2)*(2*k+3)) : longint'((2*k+1)*(2*k+2));
            n = ((longint'(2) << FRAC) + d) / (2*d);
            tab[k*WIDTH +: WIDTH] = WIDTH'(-n);
        end
        return tab;
    endfunction

    localparam logic [8*WIDTH-1:0] COS_TAB = coefTable(1'b0);
    localparam logic [8*WIDTH-1:0] SIN_TAB = coefTable(1'b1);

    state_t                  state;
    logic                    modeReg;
    logic [2:0]              k;
    logic signed [WIDTH-1:0] vReg, xReg, x2, expr, term;
    logic signed [WIDTH-1:0] coef, mulA, mulB, mulOut, addOut;
    logic signed [2*WIDTH-1:0] prod, prodShift;
    logic [WIDTH:0]          sum;

    // Coefficient for the current term index and series kind
    always_comb begin
        coef = modeReg ? SIN_TAB[int'(k)*WIDTH +: WIDTH] : COS_TAB[int'(k)*WIDTH +: WIDTH];
    end

    // Operand mux in front of the single shared multiplier
    always_comb begin
        mulA = term;
        mulB = x2;
        case (state)
            LOAD:    begin mulA = xReg; mulB = xReg; end
            ACC_B:   begin mulA = term; mulB = coef; end
            SCALE:   begin mulA = vReg; mulB = expr; end
            default: ;
        endcase
    end

    // Fixed-point multiply: full product, floor shift by FRAC, saturate to a word
    always_comb begin
        prod      = (2*WIDTH)'(mulA) * (2*WIDTH)'(mulB);
        prodShift = prod >>> FRAC;
        if (prodShift > MUL_MAX)
            mulOut = WORD_MAX;
        else if (prodShift < MUL_MIN)
            mulOut = WORD_MIN;
        else
            mulOut = prodShift[WIDTH-1:0];
    end

    // Accumulator add with one guard bit, saturated on overflow
    always_comb begin
        sum = {expr[WIDTH-1], expr} + {term[WIDTH-1], term};
        if (sum[WIDTH] != sum[WIDTH-1])
            addOut = sum[WIDTH] ? WORD_MIN : WORD_MAX;
        else
            addOut = sum[WIDTH-1:0];
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            modeReg  <= 1'b0;
            k        <= '0;
            vReg     <= '0;
            xReg     <= '0;
            x2       <= '0;
            expr     <= '0;
            term     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            series   <= '0;
            distance <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vReg    <= v_in;
                        xReg    <= x_in;
                        modeReg <= mode;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    x2    <= mulOut;
                    expr  <= '0;
                    k     <= '0;
                    term  <= modeReg ? xReg : ONE;
                    state <= ACC_A;
                end
                ACC_A: begin
                    expr  <= addOut;
                    term  <= mulOut;
                    state <= ACC_B;
                end
                ACC_B: begin
                    term <= mulOut;
                    k    <= k + 3'd1;
                    if (k == 3'(TERMS-1))
                        state <= SCALE;
                    else
                        state <= ACC_A;
                end
                SCALE: begin
                    distance <= mulOut;
                    series   <= expr;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
